// File: rtl/nanorv32_lsu_if.sv
// Core-side request/response and data-memory bus of the nanorv32 load/store unit.
// The LSU owns the slave modport; the core/memory side uses master.
interface nanorv32_lsu_if;
  logic        lsu_req;
  logic        lsu_we;
  logic [1:0]  lsu_size;
  logic        lsu_unsigned;
  logic [31:0] lsu_addr;
  logic [31:0] lsu_wdata;
  logic        lsu_busy;
  logic        lsu_done;
  logic [31:0] lsu_rdata;
  logic        lsu_misaligned;
  logic        lsu_timeout;
  logic        dmem_req;
  logic        dmem_we;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;

  modport slave (
    input  lsu_req, lsu_we, lsu_size, lsu_unsigned, lsu_addr, lsu_wdata,
    output lsu_busy, lsu_done, lsu_rdata, lsu_misaligned, lsu_timeout,
    output dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata,
    input  dmem_ready, dmem_rdata
  );

  modport master (
    output lsu_req, lsu_we, lsu_size, lsu_unsigned, lsu_addr, lsu_wdata,
    input  lsu_busy, lsu_done, lsu_rdata, lsu_misaligned, lsu_timeout,
    input  dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata,
    output dmem_ready, dmem_rdata
  );
endinterface

// File: rtl/nanorv32_lsu.sv
// nanorv32 load/store unit: one data-memory access per request with lane steering,
// load extension, misalignment rejection and an optional bus timeout.
module nanorv32_lsu #(
  parameter int NANORV32_LSU_TIMEOUT = 0,
  parameter int NANORV32_LSU_TMO_W   = 8
) (
  input  logic          clk,
  input  logic          rst,
  nanorv32_lsu_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic [NANORV32_LSU_TMO_W-1:0] TMO_LIM =
    NANORV32_LSU_TMO_W'(NANORV32_LSU_TIMEOUT);
  localparam bit TMO_EN = (NANORV32_LSU_TIMEOUT != 0);

  state_t state_q, state_d;
  logic [NANORV32_LSU_TMO_W-1:0] cnt_q, cnt_d;
  logic [1:0]  size_q, size_d;
  logic [1:0]  alo_q, alo_d;
  logic        uns_q, uns_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [31:0] rdata_q, rdata_d;
  logic        misal_q, misal_d;
  logic        tmo_q, tmo_d;
  logic        dreq_q, dreq_d;
  logic        dwe_q, dwe_d;
  logic [3:0]  dbe_q, dbe_d;
  logic [31:0] daddr_q, daddr_d;
  logic [31:0] dwdata_q, dwdata_d;

  logic        misaligned;
  logic [31:0] shifted;
  logic [31:0] load_ext;

  always_comb begin
    misaligned = (bus.lsu_size == 2'b11) ||
                 (bus.lsu_size == 2'b01 && bus.lsu_addr[0]) ||
                 (bus.lsu_size == 2'b10 && bus.lsu_addr[1:0] != 2'b00);
  end

  // Extraction uses the attributes latched at acceptance, not the live request.
  always_comb begin
    shifted = bus.dmem_rdata >> {alo_q, 3'b000};
    case (size_q)
      2'b00:   load_ext = uns_q ? {24'h0, shifted[7:0]}  : {{24{shifted[7]}}, shifted[7:0]};
      2'b01:   load_ext = uns_q ? {16'h0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
      default: load_ext = shifted;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    size_d   = size_q;
    alo_d    = alo_q;
    uns_d    = uns_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    rdata_d  = rdata_q;
    misal_d  = 1'b0;
    tmo_d    = 1'b0;
    dreq_d   = dreq_q;
    dwe_d    = dwe_q;
    dbe_d    = dbe_q;
    daddr_d  = daddr_q;
    dwdata_d = dwdata_q;
    case (state_q)
      IDLE: begin
        if (bus.lsu_req) begin
          if (misaligned) begin
            misal_d = 1'b1;
          end else begin
            size_d  = bus.lsu_size;
            alo_d   = bus.lsu_addr[1:0];
            uns_d   = bus.lsu_unsigned;
            dwe_d   = bus.lsu_we;
            daddr_d = {bus.lsu_addr[31:2], 2'b00};
            case (bus.lsu_size)
              2'b00: begin
                dbe_d    = 4'b0001 << bus.lsu_addr[1:0];
                dwdata_d = {4{bus.lsu_wdata[7:0]}};
              end
              2'b01: begin
                dbe_d    = 4'b0011 << bus.lsu_addr[1:0];
                dwdata_d = {2{bus.lsu_wdata[15:0]}};
              end
              default: begin
                dbe_d    = 4'b1111;
                dwdata_d = bus.lsu_wdata;
              end
            endcase
            dreq_d  = 1'b1;
            busy_d  = 1'b1;
            cnt_d   = '0;
            state_d = ACCESS;
          end
        end
      end
      ACCESS: begin
        // Completion takes priority over a timeout landing in the same cycle.
        if (bus.dmem_ready) begin
          dreq_d  = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = RESP;
          if (!dwe_q) rdata_d = load_ext;
        end else if (TMO_EN && cnt_q == TMO_LIM) begin
          dreq_d  = 1'b0;
          busy_d  = 1'b0;
          tmo_d   = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end else if (TMO_EN) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      size_q   <= 2'b00;
      alo_q    <= 2'b00;
      uns_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      rdata_q  <= 32'h0;
      misal_q  <= 1'b0;
      tmo_q    <= 1'b0;
      dreq_q   <= 1'b0;
      dwe_q    <= 1'b0;
      dbe_q    <= 4'h0;
      daddr_q  <= 32'h0;
      dwdata_q <= 32'h0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      size_q   <= size_d;
      alo_q    <= alo_d;
      uns_q    <= uns_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      rdata_q  <= rdata_d;
      misal_q  <= misal_d;
      tmo_q    <= tmo_d;
      dreq_q   <= dreq_d;
      dwe_q    <= dwe_d;
      dbe_q    <= dbe_d;
      daddr_q  <= daddr_d;
      dwdata_q <= dwdata_d;
    end
  end

  assign bus.lsu_busy       = busy_q;
  assign bus.lsu_done       = done_q;
  assign bus.lsu_rdata      = rdata_q;
  assign bus.lsu_misaligned = misal_q;
  assign bus.lsu_timeout    = tmo_q;
  assign bus.dmem_req       = dreq_q;
  assign bus.dmem_we        = dwe_q;
  assign bus.dmem_be        = dbe_q;
  assign bus.dmem_addr      = daddr_q;
  assign bus.dmem_wdata     = dwdata_q;
endmodule
